// File: rtl/text_line_renderer_pkg.sv
// Purpose: shared geometry, colour width and pipeline field types for the text-line renderer and its ROMs.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package text_line_renderer_pkg;

    // Glyph cell geometry shared with the character and font ROMs.
    localparam int GLYPH_W        = 8;
    localparam int GLYPH_H        = 16;
    localparam int CHARS_PER_LINE = 16;
    localparam int RGB_W          = 3;

    // Derived widths.
    localparam int PIX_W      = 10;                     // pixel coordinate width
    localparam int COL_W      = $clog2(GLYPH_W);        // pixel column inside a glyph
    localparam int ROW_W      = $clog2(GLYPH_H);        // glyph row
    localparam int CHAR_IDX_W = $clog2(CHARS_PER_LINE); // glyph index along the line
    localparam int CODE_W     = 7;                      // ASCII code width
    localparam int FONT_A_W   = CODE_W + ROW_W;

    // Text box extent in pixels, sized to compare directly against a pixel offset.
    localparam logic [PIX_W-1:0] BOX_W = PIX_W'(GLYPH_W * CHARS_PER_LINE);
    localparam logic [PIX_W-1:0] BOX_H = PIX_W'(GLYPH_H);

    // Per-pixel fields that must stay aligned with the font ROM read.
    typedef struct packed {
        logic [COL_W-1:0] col;      // column within the glyph, 0 = leftmost
        logic             in_box;   // pixel inside the text box
        logic             video_on; // active video
    } pix_meta_t;

    // Raw syncs travelling alongside the pixel.
    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // Font words store the leftmost pixel in the MSB.
    function automatic logic glyph_pixel(input logic [GLYPH_W-1:0] word,
                                         input logic [COL_W-1:0]   col);
        return word[COL_W'(GLYPH_W - 1) - col];
    endfunction

endpackage

// File: rtl/text_line_renderer_pipe_delay.sv
// Purpose: fixed-depth register delay line used to align side-band bundles with the pixel pipeline.
// Latency: DEPTH clocks from din to dout.
// Backpressure: none; accepts one word every clock.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high clear of every stage
//   din    WIDTH-bit word entering the line
//   dout   the word presented DEPTH clocks earlier
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/text_line_renderer.sv
// Purpose: overlays one 16-glyph line of ROM text (8x16 font) on a VGA pixel stream, with optional blinking.
// Latency: 3 clocks from pixel_x/pixel_y/video_on/syncs to rgb/text_on/hsync_out/vsync_out on every path.
// Backpressure: none; the raster advances one pixel per clock and the block never stalls.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset flushing the pipeline
//   pixel_x, pixel_y      raster position from the sync generator
//   video_on              active-video flag
//   hsync_in, vsync_in    raw syncs
//   char_xy / char_code   address to / ASCII code from the combinational character ROM
//   font_addr / font_word address to / row bitmap from the font ROM (1-cycle registered read)
//   text_on               pixel lies inside the text box during active video
//   rgb                   output pixel colour
//   hsync_out, vsync_out  syncs delayed to line up with rgb
module text_line_renderer
    import text_line_renderer_pkg::*;
#(
    parameter logic [PIX_W-1:0] ORIGIN_X = 10'd256,
    parameter logic [PIX_W-1:0] ORIGIN_Y = 10'd232,
    parameter logic [RGB_W-1:0] FG_RGB   = 3'b111,
    parameter logic [RGB_W-1:0] BG_RGB   = 3'b000,
    parameter logic             BLINK_EN = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PIX_W-1:0]    pixel_x,
    input  logic [PIX_W-1:0]    pixel_y,
    input  logic                video_on,
    input  logic                hsync_in,
    input  logic                vsync_in,
    output logic [7:0]          char_xy,
    input  logic [CODE_W-1:0]   char_code,
    output logic [FONT_A_W-1:0] font_addr,
    input  logic [GLYPH_W-1:0]  font_word,
    output logic                text_on,
    output logic [RGB_W-1:0]    rgb,
    output logic                hsync_out,
    output logic                vsync_out
);

    // ------------------------------------------------------------------
    // Stage 0 (combinational): offsets into the box and character lookup.
    // A pixel left of or above the origin wraps to a large offset, so a
    // single unsigned compare per axis covers both edges of the box.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] dx;
    logic [PIX_W-1:0] dy;
    logic             in_box0;
    pix_meta_t        meta0;
    sync_t            sync0;

    assign dx      = pixel_x - ORIGIN_X;
    assign dy      = pixel_y - ORIGIN_Y;
    assign in_box0 = (dx < BOX_W) && (dy < BOX_H);

    // Single text line: the ROM row nibble is always zero.
    assign char_xy = {4'h0, dx[COL_W +: CHAR_IDX_W]};

    assign meta0 = '{col: dx[COL_W-1:0], in_box: in_box0, video_on: video_on};
    assign sync0 = '{hsync: hsync_in, vsync: vsync_in};

    // ------------------------------------------------------------------
    // Stage 1: capture the character code and glyph row that address the
    // font ROM. The remaining stage-1 fields live inside the delay lines.
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] code1;
    logic [ROW_W-1:0]  row1;

    always_ff @(posedge clk) begin
        if (reset) begin
            code1 <= '0;
            row1  <= '0;
        end else begin
            code1 <= char_code;
            row1  <= dy[ROW_W-1:0];
        end
    end

    assign font_addr = {code1, row1};

    // ------------------------------------------------------------------
    // Stages 1-2 for the per-pixel flags: two registers put them in the
    // same cycle as the font ROM output.
    // ------------------------------------------------------------------
    pix_meta_t        meta2;
    logic [$bits(pix_meta_t)-1:0] meta2_raw;

    pipe_delay #(
        .WIDTH ($bits(pix_meta_t)),
        .DEPTH (2)
    ) u_meta_delay (
        .clk   (clk),
        .reset (reset),
        .din   (meta0),
        .dout  (meta2_raw)
    );

    assign meta2 = pix_meta_t'(meta2_raw);

    // ------------------------------------------------------------------
    // Stages 1-3 for the syncs: the last register of this line is the
    // output register, so the syncs leave in the same cycle as rgb.
    // ------------------------------------------------------------------
    logic [$bits(sync_t)-1:0] sync3_raw;
    sync_t                    sync3;

    pipe_delay #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (3)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (sync0),
        .dout  (sync3_raw)
    );

    assign sync3     = sync_t'(sync3_raw);
    assign hsync_out = sync3.hsync;
    assign vsync_out = sync3.vsync;

    // ------------------------------------------------------------------
    // Blink frame counter: advances on each falling edge of the raw vsync.
    // The counter updates on the edge clock, so only pixels reaching the
    // output register afterwards see the new visibility.
    // ------------------------------------------------------------------
    logic       vsync_prev;
    logic [5:0] frame_cnt;
    logic       visible;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_prev && !vsync_in) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    // 32 frames shown, 32 frames hidden.
    assign visible = !BLINK_EN || !frame_cnt[5];

    // ------------------------------------------------------------------
    // Stage 3: pick the colour and register the outputs.
    // ------------------------------------------------------------------
    logic glyph_bit;

    assign glyph_bit = glyph_pixel(font_word, meta2.col);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb     <= '0;
            text_on <= 1'b0;
        end else begin
            text_on <= meta2.in_box && meta2.video_on;
            if (!meta2.video_on) begin
                rgb <= '0;
            end else if (meta2.in_box && glyph_bit && visible) begin
                rgb <= FG_RGB;
            end else begin
                rgb <= BG_RGB;
            end
        end
    end

endmodule

// File: tb/tb_text_line_renderer.sv
// Purpose: directed self-checking bench for text_line_renderer (default instance plus a blinking, recoloured one).
// Latency: expects every output 3 clocks after its inputs.
// Backpressure: n/a; the bench streams one pixel per clock.
module tb_text_line_renderer;

    localparam int OFF = 0;
    localparam int BG  = 1;
    localparam int FG  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;

    // Default instance (a) and blinking instance (b) with distinct colours.
    logic [7:0]  char_xy_a,   char_xy_b;
    logic [6:0]  char_code_a, char_code_b;
    logic [10:0] font_addr_a, font_addr_b;
    logic [7:0]  font_word_a, font_word_b;
    logic        text_on_a,   text_on_b;
    logic [2:0]  rgb_a,       rgb_b;
    logic        hs_a,        hs_b;
    logic        vs_a,        vs_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Character ROM: "     CREDITS" padded with spaces, 'C' in column 5.
    function automatic logic [6:0] char_rom(input logic [7:0] a);
        case (a[3:0])
            4'd5:    return 7'h43; // C
            4'd6:    return 7'h52; // R
            4'd7:    return 7'h45; // E
            4'd8:    return 7'h44; // D
            4'd9:    return 7'h49; // I
            4'd10:   return 7'h54; // T
            4'd11:   return 7'h53; // S
            default: return 7'h20;
        endcase
    endfunction

    // Font ROM: space blank, 'C' has known rows, every other glyph is solid.
    function automatic logic [7:0] font_rom(input logic [10:0] a);
        logic [6:0] code;
        logic [3:0] row;
        code = a[10:4];
        row  = a[3:0];
        if (code == 7'h20) return 8'h00;
        if (code == 7'h43) begin
            if (row == 4'd3) return 8'h3C;
            if (row == 4'd8) return 8'hC3;
            return 8'h7E;
        end
        return 8'hFF;
    endfunction

    assign char_code_a = char_rom(char_xy_a);
    assign char_code_b = char_rom(char_xy_b);

    always @(posedge clk) begin
        font_word_a <= font_rom(font_addr_a);
        font_word_b <= font_rom(font_addr_b);
    end

    text_line_renderer u_dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .char_xy   (char_xy_a),
        .char_code (char_code_a),
        .font_addr (font_addr_a),
        .font_word (font_word_a),
        .text_on   (text_on_a),
        .rgb       (rgb_a),
        .hsync_out (hs_a),
        .vsync_out (vs_a)
    );

    text_line_renderer #(
        .FG_RGB   (3'b101),
        .BG_RGB   (3'b010),
        .BLINK_EN (1'b1)
    ) u_blk (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .char_xy   (char_xy_b),
        .char_code (char_code_b),
        .font_addr (font_addr_b),
        .font_word (font_word_b),
        .text_on   (text_on_b),
        .rgb       (rgb_b),
        .hsync_out (hs_b),
        .vsync_out (vs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] rgb_of(input int cls, input bit blk);
        if (cls == OFF) return 3'b000;
        if (cls == BG)  return blk ? 3'b010 : 3'b000;
        return blk ? 3'b101 : 3'b111;
    endfunction

    typedef struct {
        int x;
        int y;
        int cls;
        bit ton;
        bit hs;
        bit vs;
    } exp_t;

    exp_t eq[$];

    // Drive one pixel for one clock; the outputs seen after this edge belong
    // to the pixel driven two calls earlier (3-clock latency).
    task automatic px(input int x, input int y, input bit von, input bit hs,
                      input bit vs, input int cls, input bit ton);
        exp_t e;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        e = '{x: x, y: y, cls: cls, ton: ton, hs: hs, vs: vs};
        eq.push_back(e);
        @(posedge clk); #1;
        if (eq.size() == 3) begin
            e = eq.pop_front();
            chk($sformatf("rgb_a x=%0d y=%0d", e.x, e.y), 32'(rgb_a), 32'(rgb_of(e.cls, 1'b0)));
            chk($sformatf("rgb_b x=%0d y=%0d", e.x, e.y), 32'(rgb_b), 32'(rgb_of(e.cls, 1'b1)));
            chk($sformatf("text_on x=%0d y=%0d", e.x, e.y), 32'(text_on_a), 32'(e.ton));
            chk($sformatf("hsync_out x=%0d y=%0d", e.x, e.y), 32'(hs_a), 32'(e.hs));
            chk($sformatf("vsync_out x=%0d y=%0d", e.x, e.y), 32'(vs_a), 32'(e.vs));
        end
    endtask

    // One vsync pulse: high for a clock, then low.
    task automatic vsync_pulse();
        vsync_in = 1'b1;
        @(posedge clk); #1;
        vsync_in = 1'b0;
    endtask

    initial begin
        int c_row3 [12] = '{BG, BG, BG, BG, FG, FG, FG, FG, BG, BG, FG, FG};

        // ---------------- reset state ----------------
        reset    = 1'b1;
        pixel_x  = 10'd298;
        pixel_y  = 10'd235;
        video_on = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset rgb_a", 32'(rgb_a), 32'd0);
        chk("reset rgb_b", 32'(rgb_b), 32'd0);
        chk("reset text_on", 32'(text_on_a), 32'd0);
        chk("reset hsync_out", 32'(hs_a), 32'd0);
        chk("reset vsync_out", 32'(vs_a), 32'd0);
        chk("reset font_addr", 32'(font_addr_a), 32'd0);
        reset    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;

        // ---------------- ROM addressing ----------------
        for (int x = 296; x <= 303; x++) begin
            pixel_x = 10'(x);
            pixel_y = 10'd232;
            #1;
            chk($sformatf("char_xy x=%0d", x), 32'(char_xy_a), 32'h05);
            @(posedge clk); #1;
            chk($sformatf("font_addr x=%0d", x), 32'(font_addr_a), 32'h430);
        end
        pixel_x = 10'd295; #1;
        chk("char_xy x=295", 32'(char_xy_a), 32'h04);
        pixel_x = 10'd304; #1;
        chk("char_xy x=304", 32'(char_xy_a), 32'h06);
        pixel_x = 10'd383; #1;
        chk("char_xy x=383", 32'(char_xy_a), 32'h0F);
        @(posedge clk); #1;

        // ---------------- streamed pixels ----------------
        eq.delete();
        // 'C' row 3 (0x3C) flanked by a blank cell and a solid 'R'.
        for (int i = 0; i < 12; i++) begin
            px(294 + i, 235, 1'b1, 1'b0, 1'b0, c_row3[i], 1'b1);
        end
        // Box edges on row 8 ('C' row = 0xC3).
        px(255, 240, 1'b1, 1'b0, 1'b0, BG, 1'b0);
        px(256, 240, 1'b1, 1'b0, 1'b0, BG, 1'b1);
        px(296, 240, 1'b1, 1'b0, 1'b0, FG, 1'b1);
        px(298, 240, 1'b1, 1'b0, 1'b0, BG, 1'b1);
        px(383, 240, 1'b1, 1'b0, 1'b0, BG, 1'b1);
        px(384, 240, 1'b1, 1'b0, 1'b0, BG, 1'b0);
        px(300, 231, 1'b1, 1'b0, 1'b0, BG, 1'b0);
        px(300, 247, 1'b1, 1'b0, 1'b0, FG, 1'b1);
        px(300, 248, 1'b1, 1'b0, 1'b0, BG, 1'b0);
        // Blanking inside the box, hsync and vsync pulses.
        px(298, 235, 1'b0, 1'b0, 1'b0, OFF, 1'b0);
        px(298, 235, 1'b0, 1'b1, 1'b0, OFF, 1'b0);
        px(298, 235, 1'b0, 1'b1, 1'b0, OFF, 1'b0);
        px(298, 235, 1'b1, 1'b0, 1'b0, FG, 1'b1);
        px(298, 235, 1'b1, 1'b0, 1'b1, FG, 1'b1);
        px(298, 235, 1'b1, 1'b1, 1'b0, FG, 1'b1);
        px(0, 0, 1'b0, 1'b0, 1'b0, OFF, 1'b0);
        px(0, 0, 1'b0, 1'b0, 1'b0, OFF, 1'b0);

        // ---------------- blinking ----------------
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        pixel_x  = 10'd298;
        pixel_y  = 10'd235;
        video_on = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("blink frame0 rgb_b", 32'(rgb_b), 32'b101);
        for (int n = 1; n <= 64; n++) begin
            vsync_pulse();
            @(posedge clk); #1;
            if (n == 32) chk("blink edge cycle rgb_b", 32'(rgb_b), 32'b101);
            @(posedge clk); #1;
            if (n == 32) chk("blink after edge rgb_b", 32'(rgb_b), 32'b010);
            repeat (2) @(posedge clk);
            #1;
            if (n == 31 || n == 64) chk($sformatf("blink frame%0d rgb_b", n), 32'(rgb_b), 32'b101);
            if (n == 32 || n == 63) chk($sformatf("blink frame%0d rgb_b", n), 32'(rgb_b), 32'b010);
            if (n == 32) chk("no blink rgb_a", 32'(rgb_a), 32'b111);
        end

        // ---------------- mid-line reset ----------------
        for (int n = 0; n < 40; n++) begin
            vsync_pulse();
            @(posedge clk); #1;
        end
        hsync_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset rgb_b hidden", 32'(rgb_b), 32'b010);
        chk("pre-reset hsync_out", 32'(hs_a), 32'd1);
        chk("pre-reset text_on", 32'(text_on_a), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst rgb_a", 32'(rgb_a), 32'd0);
        chk("rst rgb_b", 32'(rgb_b), 32'd0);
        chk("rst text_on", 32'(text_on_a), 32'd0);
        chk("rst hsync_out", 32'(hs_a), 32'd0);
        chk("rst vsync_out", 32'(vs_a), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("flush+%0d text_on", k), 32'(text_on_a), 32'd0);
            chk($sformatf("flush+%0d hsync_out", k), 32'(hs_a), 32'd0);
            chk($sformatf("flush+%0d rgb_a", k), 32'(rgb_a), 32'd0);
        end
        @(posedge clk); #1;
        chk("resume rgb_a", 32'(rgb_a), 32'b111);
        chk("resume text_on", 32'(text_on_a), 32'd1);
        chk("resume hsync_out", 32'(hs_a), 32'd1);
        chk("resume rgb_b frame_cnt 0", 32'(rgb_b), 32'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/text_line_renderer.md
TEXT_LINE_RENDERER -- requirements
Module: text_line_renderer

Interface
REQ-001 Parameter ORIGIN_X, default 10'd256: pixel column of the line's left edge.
REQ-002 Parameter ORIGIN_Y, default 10'd232: pixel row of the line's top edge.
REQ-003 Parameter FG_RGB, default 3'b111: glyph-on colour.
REQ-004 Parameter BG_RGB, default 3'b000: colour inside the text box where the glyph is off, and outside the box.
REQ-005 Parameter BLINK_EN, default 1'b0: enables blinking.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pixel_x  in  10  current pixel column from the VGA sync generator.
REQ-009 pixel_y  in  10  current pixel row.
REQ-010 video_on  in  1  active-video flag.
REQ-011 hsync_in, vsync_in  in  1 each  raw syncs.
REQ-012 char_xy  out  8  address to the 16x1 character ROM ({row nibble, column nibble}).
REQ-013 char_code  in  7  ASCII code returned combinationally by the character ROM.
REQ-014 font_addr  out  11  {char_code, glyph row[3:0]} to the font ROM.
REQ-015 font_word  in  8  font ROM data, registered, 1-cycle read latency; bit 7 is the leftmost pixel.
REQ-016 text_on  out  1  pixel lies inside the 128x16 text box.
REQ-017 rgb  out  3  pixel colour.
REQ-018 hsync_out, vsync_out  out  1 each  syncs delayed to align with rgb.

Function
REQ-019 The text box SHALL cover x in [ORIGIN_X, ORIGIN_X+127] and y in [ORIGIN_Y, ORIGIN_Y+15]: 16 glyphs of 8x16 pixels.
REQ-020 Stage 0 SHALL be combinational: dx = pixel_x-ORIGIN_X, dy = pixel_y-ORIGIN_Y (10-bit, wrap ignored), in_box from unsigned compares; char_xy = {4'h0, dx[6:3]}.
REQ-021 Stage 1 register SHALL capture char_code, dy[3:0], dx[2:0], in_box, video_on, hsync_in and vsync_in.
REQ-022 font_addr SHALL equal {stage-1 char_code, stage-1 dy[3:0]} combinationally.
REQ-023 Stage 2 register SHALL delay the stage-1 fields one cycle, aligned with font_word.
REQ-024 Stage 3 register SHALL drive the outputs.
  - glyph_bit = font_word[7 - dx2].
  - rgb = FG_RGB if video_on2 & in_box2 & glyph_bit & visible; BG_RGB if video_on2 & !(that); 3'b000 if !video_on2.
  - text_on = in_box2 & video_on2.
REQ-025 Latency from pixel_x/pixel_y/video_on/syncs to rgb/text_on/sync outputs SHALL be exactly 3 clocks, identical for every path.
REQ-026 Blink frame counter: 6-bit counter incremented once per frame on a detected vsync_in falling edge (previous-sample register), wrapping 63->0.
  - visible = !BLINK_EN | !frame_cnt[5], i.e. 32 frames on, 32 frames off.
REQ-027 Boundaries:
  - pixel_x = ORIGIN_X+127 -> column 15, in box; ORIGIN_X+128 -> outside.
  - pixel_x < ORIGIN_X -> outside (subtraction wrap gives dx > 127).
  - A vsync edge coinciding with an in-box pixel changes visible only for pixels entering stage 3 on the following cycle.

Reset
REQ-028 While reset is high, all pipeline registers, frame_cnt and the vsync-history register SHALL clear to 0; rgb = 3'b000, text_on = 0, hsync_out = vsync_out = 0.
REQ-029 A reset asserted mid-line SHALL flush the pipeline.
  - Outputs show reset values for the reset cycle(s).
  - Valid outputs resume 3 clocks after reset deasserts.

Structure
REQ-030 The glyph size constants (8, 16), CHARS_PER_LINE = 16 and the RGB width SHALL live in a shared package/include used by both ROMs and this renderer.
REQ-031 The 3-stage alignment delay SHALL be one sub-module, pipe_delay (parameter WIDTH, DEPTH), instantiated for the sync/flag bundle.

Verification
REQ-032 Defaults, ROM reporting "  CREDITS" (col5='C'); drive pixel_x = 296..303, y = 232 -> char_xy = 8'h05 in the same cycle, and font_addr = {7'h43, 4'h0} one clock later.
REQ-033 Font row 0x3C for 'C' row 3 at x = 296..303 -> rgb sequence 000,000,111,111,111,111,000,000, exactly 3 clocks after the inputs.
REQ-034 pixel_x = 255 and 384, y = 240, video_on = 1 -> text_on = 0, rgb = BG_RGB; pixel_x = 383 -> text_on = 1.
REQ-035 video_on = 0 inside the box -> rgb = 000; hsync_in pulse -> hsync_out identical pulse, delayed 3 clocks.
REQ-036 BLINK_EN = 1, 64 vsync falling edges -> glyph pixels FG for frames 0-31, BG for frames 32-63, FG again at frame 64.
REQ-037 Reset asserted for 1 clock mid-line:
  - All outputs 0 on the next edge.
  - First valid rgb 3 clocks after deassert.
  - frame_cnt restarts at 0.
